// File: rtl/adding_pkg.sv
// Shared definitions for the multi-lane adding pipe: mode encodings and the lane adder helper.
package adding_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_ACC = 1'b1;

    // Widest lane the helper supports; callers zero-extend operands and truncate the result.
    localparam int LANE_MAX_W = 64;

    // Returns {carry, sum} for two unsigned operands; the carry lands at bit WIDTH of the caller's lane.
    function automatic logic [LANE_MAX_W:0] lane_add(input logic [LANE_MAX_W-1:0] x,
                                                     input logic [LANE_MAX_W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

endpackage

// File: rtl/adding_lane.sv
// One lane of the adding pipe: adder, accumulator, optional saturation and output register.
// Saturation on carry-out is enabled by defining ADDING_PIPE_SAT_EN.
module adding_lane
    import adding_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             accept_i,
    input  logic             mode_i,
    input  logic             clr_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    typedef logic [WIDTH:0] full_t;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] acc_base;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    full_t            full;

    always_comb begin
        // A clear in the same cycle as an ACC accept takes effect before the add.
        acc_base = clr_i ? '0 : acc_q;
        op_b     = (mode_i == MODE_ACC) ? acc_base : b_i;
        full     = full_t'(lane_add(LANE_MAX_W'(a_i), LANE_MAX_W'(op_b)));
        res      = full[WIDTH-1:0];
`ifdef ADDING_PIPE_SAT_EN
        if (full[WIDTH]) begin
            res = '1;
        end
`else
`endif
        acc_d   = acc_base;
        sum_d   = sum_q;
        carry_d = carry_q;
        if (accept_i) begin
            sum_d   = res;
            carry_d = full[WIDTH];
            if (mode_i == MODE_ACC) begin
                acc_d = res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/adding_pipe.sv
// Registered multi-lane adder with per-lane accumulate mode and valid/ready on both sides.
// Define ADDING_PIPE_SAT_EN to saturate lane results on carry-out instead of wrapping.
module adding_pipe
    import adding_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      mode,
    input  logic                      clr_acc,
    input  logic [CHANNELS*WIDTH-1:0] a,
    input  logic [CHANNELS*WIDTH-1:0] b,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [CHANNELS*WIDTH-1:0] sum,
    output logic [CHANNELS-1:0]       carry
);

    logic out_valid_q, out_valid_d;
    logic accept;

    // A single output slot: free when empty or being drained this cycle.
    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
            adding_lane #(
                .WIDTH(WIDTH)
            ) u_lane (
                .clk     (clk),
                .rst     (rst),
                .accept_i(accept),
                .mode_i  (mode),
                .clr_i   (clr_acc),
                .a_i     (a[gi*WIDTH +: WIDTH]),
                .b_i     (b[gi*WIDTH +: WIDTH]),
                .sum_o   (sum[gi*WIDTH +: WIDTH]),
                .carry_o (carry[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_adding_pipe.sv
// Scoreboard bench: directed checks on a 4-bit/2-lane instance, random stress on an 8-bit/4-lane one.
module tb_adding_pipe;
    import adding_pkg::*;

`ifdef ADDING_PIPE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] sum;
        logic [3:0]  carry;
    } exp_t;

    logic clk;
    // small instance: WIDTH=4, CHANNELS=2
    logic       rst_s, in_valid_s, in_ready_s, mode_s, clr_s, out_valid_s, out_ready_s;
    logic [7:0] a_s, b_s, sum_s;
    logic [1:0] carry_s;
    // stress instance: WIDTH=8, CHANNELS=4
    logic        rst_r, in_valid_r, in_ready_r, mode_r, clr_r, out_valid_r, out_ready_r;
    logic [31:0] a_r, b_r, sum_r;
    logic [3:0]  carry_r;

    int checks = 0;
    int errors = 0;
    exp_t q_s[$];
    exp_t q_r[$];
    int unsigned acc_s[2];
    int unsigned acc_r[4];

    adding_pipe #(.WIDTH(4), .CHANNELS(2)) dut_s (
        .clk(clk), .rst(rst_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .mode(mode_s), .clr_acc(clr_s), .a(a_s), .b(b_s),
        .out_valid(out_valid_s), .out_ready(out_ready_s), .sum(sum_s), .carry(carry_s)
    );

    adding_pipe #(.WIDTH(8), .CHANNELS(4)) dut_r (
        .clk(clk), .rst(rst_r), .in_valid(in_valid_r), .in_ready(in_ready_r),
        .mode(mode_r), .clr_acc(clr_r), .a(a_r), .b(b_r),
        .out_valid(out_valid_r), .out_ready(out_ready_r), .sum(sum_r), .carry(carry_r)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Unsigned lane arithmetic from first principles.
    function automatic void lane_model(input int unsigned w, input int unsigned x,
                                       input int unsigned y, output int unsigned s, output bit c);
        int unsigned full;
        int unsigned lim;
        full = x + y;
        lim  = 32'd1 << w;
        c    = (full >= lim);
        if (!c)      s = full;
        else if (SAT) s = lim - 1;
        else          s = full - lim;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step_s(input logic v, input logic m, input logic c,
                          input logic [7:0] av, input logic [7:0] bv, input logic ordy);
        exp_t e;
        int unsigned s;
        bit cy;
        in_valid_s = v; mode_s = m; clr_s = c; a_s = av; b_s = bv; out_ready_s = ordy;
        @(negedge clk);
        if (c) begin
            for (int i = 0; i < 2; i++) acc_s[i] = 0;
        end
        if (v && in_ready_s) begin
            e = '0;
            for (int i = 0; i < 2; i++) begin
                lane_model(4, (32'(av) >> (4*i)) & 15,
                           (m == MODE_ACC) ? acc_s[i] : ((32'(bv) >> (4*i)) & 15), s, cy);
                e.sum[4*i +: 4] = s[3:0];
                e.carry[i]      = cy;
                if (m == MODE_ACC) acc_s[i] = s;
            end
            q_s.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step_r(input logic v, input logic m, input logic c,
                          input logic [31:0] av, input logic [31:0] bv, input logic ordy);
        exp_t e;
        int unsigned s;
        bit cy;
        in_valid_r = v; mode_r = m; clr_r = c; a_r = av; b_r = bv; out_ready_r = ordy;
        @(negedge clk);
        if (c) begin
            for (int i = 0; i < 4; i++) acc_r[i] = 0;
        end
        if (v && in_ready_r) begin
            e = '0;
            for (int i = 0; i < 4; i++) begin
                lane_model(8, (av >> (8*i)) & 255,
                           (m == MODE_ACC) ? acc_r[i] : ((bv >> (8*i)) & 255), s, cy);
                e.sum[8*i +: 8] = s[7:0];
                e.carry[i]      = cy;
                if (m == MODE_ACC) acc_r[i] = s;
            end
            q_r.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // Monitor: a transfer happens at the next rising edge whenever valid and ready are both high.
    initial begin
        exp_t e;
        int n_s = 0;
        int n_r = 0;
        forever begin
            @(negedge clk);
            if (!rst_s && out_valid_s && out_ready_s) begin
                checks++;
                if (q_s.size() == 0) begin
                    errors++;
                    $display("FAIL sb_small_unexpected actual sum=%h carry=%b required no output", sum_s, carry_s);
                end else begin
                    e = q_s.pop_front();
                    n_s++;
                    $display("txn small #%0d sum=%h carry=%b", n_s, sum_s, carry_s);
                    if (sum_s !== e.sum[7:0] || carry_s !== e.carry[1:0]) begin
                        errors++;
                        $display("FAIL sb_small actual sum=%h carry=%b required sum=%h carry=%b",
                                 sum_s, carry_s, e.sum[7:0], e.carry[1:0]);
                    end
                end
            end
            if (!rst_r && out_valid_r && out_ready_r) begin
                checks++;
                if (q_r.size() == 0) begin
                    errors++;
                    $display("FAIL sb_stress_unexpected actual sum=%h carry=%b required no output", sum_r, carry_r);
                end else begin
                    e = q_r.pop_front();
                    n_r++;
                    $display("txn stress #%0d sum=%h carry=%b", n_r, sum_r, carry_r);
                    if (sum_r !== e.sum || carry_r !== e.carry) begin
                        errors++;
                        $display("FAIL sb_stress actual sum=%h carry=%b required sum=%h carry=%b",
                                 sum_r, carry_r, e.sum, e.carry);
                    end
                end
            end
        end
    end

    initial begin
        rst_s = 1'b1; rst_r = 1'b1;
        in_valid_s = 0; mode_s = 0; clr_s = 0; a_s = '0; b_s = '0; out_ready_s = 0;
        in_valid_r = 0; mode_r = 0; clr_r = 0; a_r = '0; b_r = '0; out_ready_r = 0;
        acc_s = '{default: 0};
        acc_r = '{default: 0};
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", 64'(out_valid_s), 64'(0));
        chk("reset_sum", 64'(sum_s), 64'(0));
        chk("reset_carry", 64'(carry_s), 64'(0));
        chk("reset_in_ready", 64'(in_ready_s), 64'(1));
        chk("reset_out_valid_stress", 64'(out_valid_r), 64'(0));
        rst_s = 1'b0; rst_r = 1'b0;
        @(posedge clk); #1;

        // ADD with a carry in lane 1
        step_s(1, MODE_ADD, 0, 8'h93, 8'h95, 0);
        chk("add_out_valid", 64'(out_valid_s), 64'(1));
        chk("add_sum", 64'(sum_s), SAT ? 64'hF8 : 64'h28);
        chk("add_carry", 64'(carry_s), 64'(2'b10));

        // ACC lane0 a=6 three times
        step_s(1, MODE_ACC, 0, 8'h06, 8'hFF, 1);
        step_s(1, MODE_ACC, 0, 8'h06, 8'hFF, 1);
        step_s(1, MODE_ACC, 0, 8'h06, 8'hFF, 1);
        chk("acc_third_sum", 64'(sum_s), SAT ? 64'h0F : 64'h02);
        chk("acc_third_carry", 64'(carry_s), 64'(2'b01));

        // Backpressure: result 0x83 must hold while offered bundles are refused
        step_s(1, MODE_ADD, 0, 8'h72, 8'h11, 1);
        for (int i = 0; i < 5; i++) begin
            step_s(1, MODE_ADD, 0, 8'($urandom), 8'($urandom), 0);
            chk("bp_in_ready", 64'(in_ready_s), 64'(0));
            chk("bp_sum_stable", 64'(sum_s), 64'h83);
            chk("bp_carry_stable", 64'(carry_s), 64'(0));
        end
        step_s(1, MODE_ADD, 0, 8'h44, 8'h21, 1);
        chk("bp_release_sum", 64'(sum_s), 64'h65);

        // clr_acc interplay
        step_s(1, MODE_ACC, 1, 8'h0A, 8'h00, 1);
        step_s(1, MODE_ACC, 1, 8'h04, 8'h00, 1);
        chk("clr_acc_sum", 64'(sum_s), 64'h04);
        chk("clr_acc_carry", 64'(carry_s), 64'(0));
        step_s(0, MODE_ADD, 1, 8'h00, 8'h00, 0);
        chk("clr_alone_out_valid", 64'(out_valid_s), 64'(1));
        chk("clr_alone_sum", 64'(sum_s), 64'h04);
        step_s(0, MODE_ADD, 0, 8'h00, 8'h00, 1);
        step_s(1, MODE_ACC, 0, 8'h01, 8'h00, 1);
        chk("after_clr_acc_sum", 64'(sum_s), 64'h01);

        // Asynchronous reset with a pending output
        step_s(1, MODE_ADD, 0, 8'h11, 8'h11, 0);
        in_valid_s = 0; out_ready_s = 0;
        #2 rst_s = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid_s), 64'(0));
        chk("async_rst_sum", 64'(sum_s), 64'(0));
        chk("async_rst_carry", 64'(carry_s), 64'(0));
        q_s.delete();
        acc_s = '{default: 0};
        @(posedge clk); #1;
        rst_s = 1'b0;
        step_s(1, MODE_ACC, 0, 8'h02, 8'h00, 1);
        chk("post_rst_acc_sum", 64'(sum_s), 64'h02);
        step_s(0, MODE_ADD, 0, 8'h00, 8'h00, 1);
        step_s(0, MODE_ADD, 0, 8'h00, 8'h00, 1);

        // Random stress on the wide instance
        for (int i = 0; i < 800; i++) begin
            step_r(($urandom % 4) != 0, 1'($urandom), ($urandom % 16) == 0,
                   $urandom, $urandom, ($urandom % 4) != 0);
        end
        for (int i = 0; i < 3; i++) step_r(0, MODE_ADD, 0, '0, '0, 1);

        chk("small_queue_drained", 64'(q_s.size()), 64'(0));
        chk("stress_queue_drained", 64'(q_r.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
